// File: rtl/isa_fill.sv
// Multi-register fill unit: writes a zero/ones/immediate/ramp pattern into
// `count` consecutive registers from r0, one register-file write per cycle.
module isa_fill #(
    parameter int DATA_W   = 64,
    parameter int REG_ID_W = 4,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enabled,
    input  logic [REG_ID_W-1:0] r0,
    input  logic [CNT_W-1:0]    count,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   imm,
    output logic [REG_ID_W-1:0] reg_id,
    output logic [DATA_W-1:0]   reg_wd,
    output logic                reg_we,
    output logic                finished
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ZERO = 2'd0;
    localparam logic [1:0] MODE_ONES = 2'd1;
    localparam logic [1:0] MODE_IMM  = 2'd2;
    localparam logic [1:0] MODE_RAMP = 2'd3;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [REG_ID_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   imm_q, imm_d;

    logic [CNT_W-1:0]    last_idx;

    assign last_idx = cnt_q - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_ZERO;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            imm_q   <= imm_d;
        end
    end

    // Operands are captured only on the IDLE exit edge so the decoder may
    // change its inputs freely while the instruction runs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        imm_d   = imm_q;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (enabled) begin
                    base_d = r0;
                    cnt_d  = count;
                    mode_d = mode;
                    imm_d  = imm;
                    if (count != '0) begin
                        state_d = WRITE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (!enabled) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (idx_q == last_idx) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            DONE: begin
                idx_d = '0;
                if (!enabled) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // The write port is a pure function of the latched operands and idx; the
    // index addition wraps naturally at the register-file size.
    always_comb begin
        reg_we   = (state_q == WRITE);
        finished = (state_q == DONE);
        reg_id   = base_q + idx_q[REG_ID_W-1:0];
        reg_wd   = '0;
        case (mode_q)
            MODE_ZERO: reg_wd = '0;
            MODE_ONES: reg_wd = '1;
            MODE_IMM:  reg_wd = imm_q;
            MODE_RAMP: reg_wd = imm_q + DATA_W'(idx_q);
            default:   reg_wd = '0;
        endcase
    end

endmodule

// File: tb/tb_isa_fill.sv
// Scoreboard bench for isa_fill: expected writes are queued by the stimulus
// and popped by a monitor whenever the DUT presents reg_we.
module tb_isa_fill;

    localparam int DATA_W   = 64;
    localparam int REG_ID_W = 4;
    localparam int CNT_W    = 5;
    localparam int NREGS    = 1 << REG_ID_W;

    typedef struct packed {
        logic [REG_ID_W-1:0] id;
        logic [DATA_W-1:0]   wd;
    } wr_t;

    logic                clk;
    logic                rst_n;
    logic                enabled;
    logic [REG_ID_W-1:0] r0;
    logic [CNT_W-1:0]    count;
    logic [1:0]          mode;
    logic [DATA_W-1:0]   imm;
    logic [REG_ID_W-1:0] reg_id;
    logic [DATA_W-1:0]   reg_wd;
    logic                reg_we;
    logic                finished;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] regs_model[NREGS];
    int                errors;
    int                checks;
    int                cycles;

    isa_fill #(
        .DATA_W  (DATA_W),
        .REG_ID_W(REG_ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enabled (enabled),
        .r0      (r0),
        .count   (count),
        .mode    (mode),
        .imm     (imm),
        .reg_id  (reg_id),
        .reg_wd  (reg_wd),
        .reg_we  (reg_we),
        .finished(finished)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic logic [DATA_W-1:0] sentinel(input int i);
        return 64'hDEAD_BEEF_0000_0000 | 64'(i);
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWrite(input logic [REG_ID_W-1:0] id, input logic [DATA_W-1:0] wd);
        wr_t w;
        w.id = id;
        w.wd = wd;
        exp_q.push_back(w);
    endtask

    task automatic applyStimulus(input logic [REG_ID_W-1:0] r0_i, input logic [CNT_W-1:0] count_i,
                                 input logic [1:0] mode_i, input logic [DATA_W-1:0] imm_i);
        r0      = r0_i;
        count   = count_i;
        mode    = mode_i;
        imm     = imm_i;
        enabled = 1'b1;
    endtask

    // Wait for finished; the operand inputs are scrambled after the first
    // edge to show the unit works from its latched copies.
    task automatic waitFinished(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n = n + 1;
            if (n == 1) begin
                r0    = 4'h9;
                count = 5'd31;
                mode  = 2'd2;
                imm   = 64'h0BAD_0BAD_0BAD_0BAD;
            end
        end while (!finished && n < budget);
    endtask

    task automatic clearModel();
        for (int i = 0; i < NREGS; i++) begin
            regs_model[i] = sentinel(i);
        end
    endtask

    task automatic monitor();
        wr_t w;
        forever begin
            tick();
            checks = checks + 1;
            if (reg_we && finished) begin
                errors = errors + 1;
                $display("[TB] FAIL we_and_finished: got both high expected exclusive");
            end
            if (reg_we) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("[TB] FAIL unexpected_write: got id=%0d wd=0x%0h expected no write",
                             reg_id, reg_wd);
                end else begin
                    w = exp_q.pop_front();
                    checkOutput("write_id", DATA_W'(reg_id), DATA_W'(w.id));
                    checkOutput("write_wd", reg_wd, w.wd);
                end
            end
        end
    endtask

    task automatic regFileModel();
        forever begin
            @(posedge clk);
            if (reg_we === 1'b1) begin
                regs_model[reg_id] = reg_wd;
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        enabled = 1'b0;
        r0      = '0;
        count   = '0;
        mode    = '0;
        imm     = '0;
        clearModel();
        fork
            monitor();
            regFileModel();
        join_none

        // Reset values
        tick();
        tick();
        checkOutput("reset_we", DATA_W'(reg_we), 64'd0);
        checkOutput("reset_finished", DATA_W'(finished), 64'd0);
        checkOutput("reset_id", DATA_W'(reg_id), 64'd0);
        checkOutput("reset_wd", reg_wd, 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] zero fill r0=3 count=4");
        clearModel();
        applyStimulus(4'd3, 5'd4, 2'd0, 64'h1234);
        pushWrite(4'd3, 64'd0);
        pushWrite(4'd4, 64'd0);
        pushWrite(4'd5, 64'd0);
        pushWrite(4'd6, 64'd0);
        waitFinished(20, cycles);
        checkOutput("zero_latency", 64'(cycles), 64'd5);
        checkOutput("zero_finished", DATA_W'(finished), 64'd1);
        tick();
        checkOutput("zero_hold_finished", DATA_W'(finished), 64'd1);
        checkOutput("zero_hold_we", DATA_W'(reg_we), 64'd0);
        enabled = 1'b0;
        tick();
        checkOutput("zero_finished_drop", DATA_W'(finished), 64'd0);
        checkOutput("zero_reg2", regs_model[2], sentinel(2));
        checkOutput("zero_reg3", regs_model[3], 64'd0);
        checkOutput("zero_reg6", regs_model[6], 64'd0);
        checkOutput("zero_reg7", regs_model[7], sentinel(7));

        $display("[TB] ramp with wrap r0=14 count=4");
        clearModel();
        applyStimulus(4'd14, 5'd4, 2'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        pushWrite(4'd14, 64'hFFFF_FFFF_FFFF_FFFE);
        pushWrite(4'd15, 64'hFFFF_FFFF_FFFF_FFFF);
        pushWrite(4'd0, 64'h0);
        pushWrite(4'd1, 64'h1);
        waitFinished(20, cycles);
        checkOutput("ramp_latency", 64'(cycles), 64'd5);
        enabled = 1'b0;
        tick();
        checkOutput("ramp_reg15", regs_model[15], 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("ramp_reg0", regs_model[0], 64'h0);
        checkOutput("ramp_reg1", regs_model[1], 64'h1);
        checkOutput("ramp_reg2", regs_model[2], sentinel(2));

        $display("[TB] count zero");
        applyStimulus(4'd5, 5'd0, 2'd1, 64'h0);
        waitFinished(20, cycles);
        checkOutput("cnt0_latency", 64'(cycles), 64'd1);
        checkOutput("cnt0_we", DATA_W'(reg_we), 64'd0);
        enabled = 1'b0;
        tick();
        checkOutput("cnt0_finished_drop", DATA_W'(finished), 64'd0);

        $display("[TB] abort after three writes");
        clearModel();
        applyStimulus(4'd0, 5'd8, 2'd2, 64'hA5);
        pushWrite(4'd0, 64'hA5);
        pushWrite(4'd1, 64'hA5);
        pushWrite(4'd2, 64'hA5);
        tick();
        tick();
        tick();
        enabled = 1'b0;
        tick();
        checkOutput("abort_we", DATA_W'(reg_we), 64'd0);
        checkOutput("abort_finished", DATA_W'(finished), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("abort_finished_quiet", DATA_W'(finished), 64'd0);
        end
        checkOutput("abort_reg0", regs_model[0], 64'hA5);
        checkOutput("abort_reg2", regs_model[2], 64'hA5);
        checkOutput("abort_reg3", regs_model[3], sentinel(3));

        $display("[TB] back-to-back fills");
        clearModel();
        applyStimulus(4'd1, 5'd2, 2'd1, 64'h0);
        pushWrite(4'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        pushWrite(4'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        waitFinished(20, cycles);
        checkOutput("b2b_first_latency", 64'(cycles), 64'd3);
        enabled = 1'b0;
        tick();
        applyStimulus(4'd1, 5'd1, 2'd0, 64'h77);
        pushWrite(4'd1, 64'd0);
        waitFinished(20, cycles);
        checkOutput("b2b_second_latency", 64'(cycles), 64'd2);
        enabled = 1'b0;
        tick();
        checkOutput("b2b_reg1", regs_model[1], 64'd0);
        checkOutput("b2b_reg2", regs_model[2], 64'hFFFF_FFFF_FFFF_FFFF);

        $display("[TB] reset during third write");
        clearModel();
        applyStimulus(4'd5, 5'd6, 2'd2, 64'h77);
        pushWrite(4'd5, 64'h77);
        pushWrite(4'd6, 64'h77);
        pushWrite(4'd7, 64'h77);
        tick();
        tick();
        tick();
        checkOutput("rst_pre_we", DATA_W'(reg_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_we", DATA_W'(reg_we), 64'd0);
        checkOutput("rst_async_finished", DATA_W'(finished), 64'd0);
        enabled = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_idle_we", DATA_W'(reg_we), 64'd0);
            checkOutput("rst_idle_finished", DATA_W'(finished), 64'd0);
        end
        checkOutput("rst_reg6", regs_model[6], 64'h77);
        checkOutput("rst_reg7", regs_model[7], sentinel(7));

        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
